// File: rtl/axis_ipg_pkt_gen.sv
// axis_ipg_pkt_gen: descriptor-driven AXI4-Stream frame generator.
// A small table of frame descriptors (length, last-beat bytes, trailing gap,
// payload seed, error flag) is replayed once or in a loop on an AXI-Stream
// master with full backpressure support.
// Optional feature macro: AXIS_IPG_PKT_GEN_STATS_EN enables the frame_count
// statistics counter; without it frame_count reads constant 0.
module axis_ipg_pkt_gen #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int DESC_DEPTH = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int GAP_WIDTH  = 8,
  parameter int AW         = $clog2(DESC_DEPTH),
  parameter int BW         = $clog2(KEEP_WIDTH)+1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_wr_en,
  input  logic [AW-1:0]         cfg_wr_addr,
  input  logic [LEN_WIDTH-1:0]  cfg_wr_len,
  input  logic [BW-1:0]         cfg_wr_lastbytes,
  input  logic [GAP_WIDTH-1:0]  cfg_wr_gap,
  input  logic [DATA_WIDTH-1:0] cfg_wr_seed,
  input  logic                  cfg_wr_err,
  input  logic [AW:0]           cfg_num_desc,
  input  logic                  cfg_loop,
  input  logic                  start,
  input  logic                  stop,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           frame_count
);

  // Descriptor as stored in the table; len and bytes are normalised on write
  // so the datapath never sees len=0 or an out-of-range byte count.
  typedef struct packed {
    logic                  err;
    logic [DATA_WIDTH-1:0] seed;
    logic [GAP_WIDTH-1:0]  gap;
    logic [BW-1:0]         bytes;
    logic [LEN_WIDTH-1:0]  len;
  } desc_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SEND  = 3'd2,
    S_GAP   = 3'd3,
    S_END   = 3'd4
  } state_t;

  state_t                state;
  desc_t                 desc_mem [0:DESC_DEPTH-1];
  desc_t                 rd_desc;
  desc_t                 wr_desc;
  logic                  wr_ok;
  logic [AW-1:0]         rd_addr;

  logic [AW-1:0]         idx;
  logic [AW-1:0]         idx_next;
  logic [AW:0]           num_reg;
  logic                  loop_reg;
  logic                  stop_pend;
  logic                  is_last_desc;
  logic                  end_run;

  logic [LEN_WIDTH-1:0]  len_reg;
  logic [LEN_WIDTH-1:0]  beat_cnt;
  logic [BW-1:0]         bytes_reg;
  logic [GAP_WIDTH-1:0]  gap_reg;
  logic [GAP_WIDTH-1:0]  gap_cnt;
  logic                  err_reg;

  logic [DATA_WIDTH-1:0] tdata_reg;
  logic [KEEP_WIDTH-1:0] tkeep_reg;
  logic                  tvalid_reg;
  logic                  tlast_reg;
  logic                  tuser_reg;
  logic                  done_reg;

  // Byte-enable mask for a last beat carrying nbytes valid bytes.
  function automatic logic [KEEP_WIDTH-1:0] keep_for(input logic [BW-1:0] nbytes);
    logic [KEEP_WIDTH-1:0] k;
    k = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      k[i] = (i < int'(nbytes));
    end
    return k;
  endfunction

  // Normalise incoming descriptor fields; the table only accepts writes in IDLE.
  always_comb begin
    wr_desc.err   = cfg_wr_err;
    wr_desc.seed  = cfg_wr_seed;
    wr_desc.gap   = cfg_wr_gap;
    wr_desc.len   = (cfg_wr_len == '0) ? LEN_WIDTH'(1) : cfg_wr_len;
    wr_desc.bytes = ((cfg_wr_lastbytes == '0) || (cfg_wr_lastbytes > BW'(KEEP_WIDTH)))
                    ? BW'(KEEP_WIDTH) : cfg_wr_lastbytes;
    wr_ok         = cfg_wr_en && (state == S_IDLE);
  end

  // Descriptor sequencing: which entry follows idx and whether the run ends here.
  always_comb begin
    is_last_desc = ({1'b0, idx} == (num_reg - (AW+1)'(1)));
    idx_next     = is_last_desc ? '0 : (idx + AW'(1));
    end_run      = stop_pend || stop || (is_last_desc && !loop_reg);
    // The read issued on the edge that enters FETCH must target the entry FETCH uses.
    rd_addr      = (state == S_IDLE) ? '0 : idx_next;
  end

  // Table RAM: write port plus registered read; a write to the entry being
  // read in the same cycle (start together with cfg_wr_en) is forwarded.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      desc_mem[cfg_wr_addr] <= wr_desc;
    end
    if (wr_ok && (cfg_wr_addr == rd_addr)) begin
      rd_desc <= wr_desc;
    end else begin
      rd_desc <= desc_mem[rd_addr];
    end
  end

  // Main sequencer with registered stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      num_reg    <= '0;
      loop_reg   <= 1'b0;
      stop_pend  <= 1'b0;
      len_reg    <= '0;
      beat_cnt   <= '0;
      bytes_reg  <= '0;
      gap_reg    <= '0;
      gap_cnt    <= '0;
      err_reg    <= 1'b0;
      tdata_reg  <= '0;
      tkeep_reg  <= '0;
      tvalid_reg <= 1'b0;
      tlast_reg  <= 1'b0;
      tuser_reg  <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (stop && (state != S_IDLE)) begin
        stop_pend <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            if (cfg_num_desc == '0) begin
              done_reg <= 1'b1;
            end else begin
              state     <= S_FETCH;
              idx       <= '0;
              num_reg   <= (cfg_num_desc > (AW+1)'(DESC_DEPTH)) ? (AW+1)'(DESC_DEPTH) : cfg_num_desc;
              loop_reg  <= cfg_loop;
              stop_pend <= stop;
            end
          end
        end
        S_FETCH: begin
          len_reg    <= rd_desc.len;
          bytes_reg  <= rd_desc.bytes;
          gap_reg    <= rd_desc.gap;
          err_reg    <= rd_desc.err;
          beat_cnt   <= '0;
          tdata_reg  <= rd_desc.seed;
          tvalid_reg <= 1'b1;
          if (rd_desc.len == LEN_WIDTH'(1)) begin
            tlast_reg <= 1'b1;
            tkeep_reg <= keep_for(rd_desc.bytes);
            tuser_reg <= rd_desc.err;
          end else begin
            tlast_reg <= 1'b0;
            tkeep_reg <= '1;
            tuser_reg <= 1'b0;
          end
          state <= S_SEND;
        end
        S_SEND: begin
          if (tvalid_reg && m_axis_tready) begin
            if (tlast_reg) begin
              tvalid_reg <= 1'b0;
              tlast_reg  <= 1'b0;
              tuser_reg  <= 1'b0;
              tkeep_reg  <= '0;
              tdata_reg  <= '0;
              if (gap_reg != '0) begin
                gap_cnt <= gap_reg;
                state   <= S_GAP;
              end else if (end_run) begin
                state <= S_END;
              end else begin
                idx   <= idx_next;
                state <= S_FETCH;
              end
            end else begin
              tdata_reg <= tdata_reg + DATA_WIDTH'(1);
              beat_cnt  <= beat_cnt + LEN_WIDTH'(1);
              if ((beat_cnt + LEN_WIDTH'(2)) == len_reg) begin
                tlast_reg <= 1'b1;
                tkeep_reg <= keep_for(bytes_reg);
                tuser_reg <= err_reg;
              end
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_WIDTH'(1)) begin
            if (end_run) begin
              state <= S_END;
            end else begin
              idx   <= idx_next;
              state <= S_FETCH;
            end
          end else begin
            gap_cnt <= gap_cnt - GAP_WIDTH'(1);
          end
        end
        S_END: begin
          done_reg <= 1'b1;
          state    <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef AXIS_IPG_PKT_GEN_STATS_EN
  logic [31:0] frame_count_reg;

  // Completed-frame counter: cleared by a start taken in IDLE, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count_reg <= '0;
    end else if ((state == S_IDLE) && start) begin
      frame_count_reg <= '0;
    end else if ((state == S_SEND) && tvalid_reg && m_axis_tready && tlast_reg &&
                 (frame_count_reg != 32'hffff_ffff)) begin
      frame_count_reg <= frame_count_reg + 32'd1;
    end
  end

  assign frame_count = frame_count_reg;
`else
  assign frame_count = 32'd0;
`endif

  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tkeep  = tkeep_reg;
  assign m_axis_tvalid = tvalid_reg;
  assign m_axis_tlast  = tlast_reg;
  assign m_axis_tuser  = tuser_reg;
  assign busy          = (state != S_IDLE);
  assign done          = done_reg;

endmodule
